// File: rtl/imem_loader_pkg.sv
// Shared definitions for the IRAM program loader: default frame header
// and the loader state encoding.
package imem_loader_pkg;

  localparam logic [7:0] HEADER_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEN   = 3'd1,
    DATA  = 3'd2,
    WRITE = 3'd3,
    CHECK = 3'd4,
    DONE  = 3'd5,
    ERR   = 3'd6
  } state_t;

endpackage

// File: rtl/imem_loader.sv
// Byte-stream program loader. Receives a framed image
// (HEADER, N, 4N payload bytes, XOR checksum), assembles little-endian
// words, writes them into IRAM and releases the core only after a
// frame with a good checksum.
//
// Handshake: a byte moves on a posedge where rxValid && rxReady.
// rxReady is low only in the WRITE cycle, and the source must hold
// rxData/rxValid stable until the byte is accepted.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int          ADDR_WIDTH = 8,
  parameter logic [7:0]  HEADER     = HEADER_DEFAULT
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic [7:0]            rxData,
  input  logic                  rxValid,
  output logic                  rxReady,
  output logic [ADDR_WIDTH-1:0] wrAddr,
  output logic [31:0]           wrData,
  output logic                  wrEn,
  output logic                  coreClear,
  output logic                  done,
  output logic                  error,
  output state_t                dbgState
);

  localparam int WORD_BITS = ADDR_WIDTH - 2;
  localparam int MAX_WORDS = 2 ** WORD_BITS;

  state_t               state;
  logic [7:0]           nWords;
  logic [WORD_BITS-1:0] wordIdx;
  logic [1:0]           byteIdx;
  logic [7:0]           chk;
  logic [23:0]          lanes;    // bytes 0..2 of the word being built
  logic                 accept;
  logic                 lastWord;

  // Ready everywhere except the single WRITE cycle.
  assign rxReady  = (state != WRITE);
  assign accept   = rxValid && rxReady;
  assign lastWord = (32'(wordIdx) == (32'(nWords) - 32'd1));
  assign dbgState = state;

  // Frame parser, word assembler and registered IRAM/core-control outputs.
  always_ff @(posedge clock) begin
    if (!clear) begin
      state     <= IDLE;
      nWords    <= 8'd0;
      wordIdx   <= '0;
      byteIdx   <= 2'd0;
      chk       <= 8'd0;
      lanes     <= 24'd0;
      wrAddr    <= '0;
      wrData    <= 32'd0;
      wrEn      <= 1'b0;
      coreClear <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept && rxData == HEADER) state <= LEN;
        end
        LEN: begin
          if (accept) begin
            // Bounding N here guarantees wrAddr never wraps.
            if (rxData == 8'd0 || 32'(rxData) > MAX_WORDS) begin
              state     <= ERR;
              error     <= 1'b1;
              done      <= 1'b0;
              coreClear <= 1'b0;
            end else begin
              nWords  <= rxData;
              wordIdx <= '0;
              byteIdx <= 2'd0;
              chk     <= 8'd0;
              state   <= DATA;
            end
          end
        end
        DATA: begin
          if (accept) begin
            chk     <= chk ^ rxData;
            byteIdx <= byteIdx + 2'd1;
            if (byteIdx == 2'd3) begin
              // The 4th byte goes straight into wrData with the held lanes.
              wrEn   <= 1'b1;
              wrAddr <= {wordIdx, 2'b00};
              wrData <= {rxData, lanes};
              state  <= WRITE;
            end else begin
              lanes[{byteIdx, 3'b000} +: 8] <= rxData;
            end
          end
        end
        WRITE: begin
          wrEn    <= 1'b0;
          wordIdx <= wordIdx + 1'b1;
          byteIdx <= 2'd0;
          state   <= lastWord ? CHECK : DATA;
        end
        CHECK: begin
          if (accept) begin
            if (rxData == chk) begin
              state     <= DONE;
              done      <= 1'b1;
              coreClear <= 1'b1;
            end else begin
              state     <= ERR;
              error     <= 1'b1;
              coreClear <= 1'b0;
            end
          end
        end
        DONE, ERR: begin
          // A new header restarts loading and holds the core again.
          if (accept && rxData == HEADER) begin
            state     <= LEN;
            done      <= 1'b0;
            error     <= 1'b0;
            coreClear <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: random framed images checked against a frame-level
// model (expected IRAM writes queue plus expected status per frame).
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int AW = 8;

  logic          clock = 1'b0;
  logic          clear = 1'b0;
  logic [7:0]    rxData = 8'd0;
  logic          rxValid = 1'b0;
  logic          rxReady;
  logic [AW-1:0] wrAddr;
  logic [31:0]   wrData;
  logic          wrEn;
  logic          coreClear;
  logic          done;
  logic          error;
  state_t        dbg_state;

  int checks = 0;
  int failures = 0;

  logic [AW+31:0] exp_q[$];     // expected {addr, data} writes in order
  logic [7:0]     frame_q[$];   // bytes of the frame under construction

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL global_timeout time=%0t limit=2000000", $time);
    $fatal(1, "bench timeout");
  end

  imem_loader #(.ADDR_WIDTH(AW), .HEADER(8'hA5)) dut (
    .clock    (clock),
    .clear    (clear),
    .rxData   (rxData),
    .rxValid  (rxValid),
    .rxReady  (rxReady),
    .wrAddr   (wrAddr),
    .wrData   (wrData),
    .wrEn     (wrEn),
    .coreClear(coreClear),
    .done     (done),
    .error    (error),
    .dbgState (dbg_state)
  );

  // ---------------- write scoreboard ----------------
  always @(negedge clock) begin
    if (wrEn === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL write_unexpected addr=%h data=%h required=no_write", wrAddr, wrData);
      end else begin
        logic [AW+31:0] e;
        e = exp_q.pop_front();
        if ({wrAddr, wrData} !== e)
          begin
            failures++;
            $display("FAIL write_content addr=%h data=%h required_addr=%h required_data=%h",
                     wrAddr, wrData, e[AW+31:32], e[31:0]);
          end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b, output int stalls);
    int cyc;
    logic rdy;
    rxData  = b;
    rxValid = 1'b1;
    stalls  = 0;
    for (cyc = 0; cyc < 20; cyc++) begin
      @(negedge clock);
      rdy = rxReady;
      @(posedge clock);
      #1;
      if (rdy === 1'b1) break;
      stalls++;
    end
    if (cyc == 20) begin
      checks++;
      failures++;
      $display("FAIL byte_accept_timeout byte=%h ready=0 required=1", b);
    end
  endtask

  task automatic idle(input int n);
    rxValid = 1'b0;
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Builds a frame of n random words and queues the writes it must cause
  // (writes happen whether or not the checksum is good).
  task automatic make_frame(input int n, input bit bad_chk);
    logic [31:0] w;
    logic [7:0]  c;
    frame_q.delete();
    frame_q.push_back(8'hA5);
    frame_q.push_back(8'(n));
    c = 8'd0;
    for (int i = 0; i < n; i++) begin
      w = $urandom;
      for (int k = 0; k < 4; k++) begin
        frame_q.push_back(w[8*k +: 8]);
        c = c ^ w[8*k +: 8];
      end
      exp_q.push_back({AW'(4 * i), w});
    end
    frame_q.push_back(bad_chk ? ~c : c);
  endtask

  // Sends frame_q[lo..hi]. Without gaps, valid stays high and the byte right
  // after each completed word must wait exactly one cycle.
  task automatic send_range(input bit gaps, input int lo, input int hi);
    int st;
    int n;
    int exp_st;
    n = (frame_q.size() - 3) / 4;
    for (int i = lo; i <= hi; i++) begin
      if (gaps && $urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
      send_byte(frame_q[i], st);
      if (!gaps) begin
        exp_st = (i >= 3 && (i - 1) <= 4 * n + 1 && ((i - 3) % 4) == 3) ? 1 : 0;
        checks++;
        if (st !== exp_st) begin
          failures++;
          $display("FAIL ready_stall byte_idx=%0d stalls=%0d required=%0d", i, st, exp_st);
        end
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    clear = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if ({wrEn, coreClear, done, error, wrAddr, wrData} !== '0) begin
      failures++;
      $display("FAIL reset_outputs wren=%b cc=%b done=%b err=%b addr=%h data=%h required=all_zero",
               wrEn, coreClear, done, error, wrAddr, wrData);
    end
    checks++;
    if (dbg_state !== IDLE) begin
      failures++;
      $display("FAIL reset_state state=%0d required=%0d", dbg_state, IDLE);
    end
    clear = 1'b1;
    #1;
    checks++;
    if (rxReady !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready ready=%b required=1", rxReady);
    end
  endtask

  task automatic load_fixed(input logic [7:0] chk_byte);
    logic [7:0] img [11];
    img = '{8'hA5, 8'h02, 8'h93, 8'h00, 8'h10, 8'h00, 8'h13, 8'h01, 8'h20, 8'h00, 8'h00};
    img[10] = chk_byte;
    frame_q.delete();
    foreach (img[i]) frame_q.push_back(img[i]);
    exp_q.push_back({AW'(0), 32'h00100093});
    exp_q.push_back({AW'(4), 32'h00200113});
    send_range(1'b0, 0, 9);
    checks++;
    if ({coreClear, done} !== 2'b00) begin
      failures++;
      $display("FAIL held_before_chk cc=%b done=%b required=00", coreClear, done);
    end
    send_range(1'b0, 10, 10);
    idle(1);
  endtask

  task automatic test_known_frame;
    load_fixed(8'hB1);
    checks++;
    if ({coreClear, done, error} !== 3'b110) begin
      failures++;
      $display("FAIL known_frame_status cc_done_err=%b required=110", {coreClear, done, error});
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL known_frame_writes missing=%0d required=0", exp_q.size());
    end
  endtask

  task automatic test_bad_chk;
    load_fixed(8'hB0);
    checks++;
    if ({coreClear, done, error} !== 3'b001) begin
      failures++;
      $display("FAIL bad_chk_status cc_done_err=%b required=001", {coreClear, done, error});
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL bad_chk_writes missing=%0d required=0", exp_q.size());
    end
  endtask

  task automatic test_bad_len;
    int st;
    clear = 1'b0;
    idle(1);
    clear = 1'b1;
    send_byte(8'h00, st);
    send_byte(8'hFF, st);
    checks++;
    if ({coreClear, done, error} !== 3'b000) begin
      failures++;
      $display("FAIL idle_ignore cc_done_err=%b required=000", {coreClear, done, error});
    end
    send_byte(8'hA5, st);
    send_byte(8'h00, st);
    checks++;
    if (error !== 1'b1) begin
      failures++;
      $display("FAIL len_zero error=%b required=1", error);
    end
    send_byte(8'hA5, st);
    checks++;
    if (error !== 1'b0) begin
      failures++;
      $display("FAIL err_header_clears error=%b required=0", error);
    end
    send_byte(8'd65, st);
    checks++;
    if ({coreClear, done, error} !== 3'b001) begin
      failures++;
      $display("FAIL len_too_big cc_done_err=%b required=001", {coreClear, done, error});
    end
    // Largest legal image fills every IRAM word.
    make_frame(64, 1'b0);
    send_range(1'b0, 0, frame_q.size() - 1);
    idle(1);
    checks++;
    if ({coreClear, done, error, exp_q.size() == 0} !== 4'b1101) begin
      failures++;
      $display("FAIL len_max cc_done_err=%b missing=%0d required=110/0",
               {coreClear, done, error}, exp_q.size());
    end
  endtask

  task automatic test_reset_mid_frame;
    make_frame(3, 1'b0);
    send_range(1'b0, 0, 5);
    // The first word's write strobe is already up in this cycle.
    clear   = 1'b0;
    rxValid = 1'b0;
    @(posedge clock);
    #1;
    checks++;
    if ({wrEn, coreClear, done, error, wrAddr, wrData} !== '0) begin
      failures++;
      $display("FAIL mid_reset_outputs wren=%b cc=%b done=%b err=%b addr=%h data=%h required=all_zero",
               wrEn, coreClear, done, error, wrAddr, wrData);
    end
    checks++;
    if (exp_q.size() != 2) begin
      failures++;
      $display("FAIL mid_reset_first_write pending=%0d required=2", exp_q.size());
    end
    exp_q.delete();
    idle(3);
    clear = 1'b1;
    idle(2);
    make_frame($urandom_range(1, 6), 1'b0);
    send_range(1'b1, 0, frame_q.size() - 1);
    idle(1);
    checks++;
    if ({coreClear, done, error, exp_q.size() == 0} !== 4'b1101) begin
      failures++;
      $display("FAIL after_reset_load cc_done_err=%b missing=%0d required=110/0",
               {coreClear, done, error}, exp_q.size());
    end
  endtask

  task automatic test_back_to_back;
    for (int f = 0; f < 2; f++) begin
      make_frame($urandom_range(2, 8), 1'b0);
      send_range(1'b0, 0, frame_q.size() - 1);
      checks++;
      if ({coreClear, done, error, exp_q.size() == 0} !== 4'b1101) begin
        failures++;
        $display("FAIL b2b_status frame=%0d cc_done_err=%b missing=%0d required=110/0",
                 f, {coreClear, done, error}, exp_q.size());
      end
    end
    idle(1);
  endtask

  task automatic test_reload;
    make_frame(1, 1'b0);
    send_range(1'b0, 0, 0);
    checks++;
    if ({coreClear, done, error} !== 3'b000) begin
      failures++;
      $display("FAIL reload_header cc_done_err=%b required=000", {coreClear, done, error});
    end
    send_range(1'b0, 1, frame_q.size() - 1);
    checks++;
    if ({coreClear, done, error} !== 3'b110) begin
      failures++;
      $display("FAIL reload_done cc_done_err=%b required=110", {coreClear, done, error});
    end
    idle(1);
  endtask

  task automatic test_random_frames;
    bit bad;
    for (int f = 0; f < 6; f++) begin
      bad = ($urandom_range(0, 2) == 0);
      make_frame($urandom_range(1, 12), bad);
      send_range(1'b1, 0, frame_q.size() - 1);
      idle(1);
      checks++;
      if ({coreClear, done, error} !== (bad ? 3'b001 : 3'b110)) begin
        failures++;
        $display("FAIL random_status frame=%0d bad=%0d cc_done_err=%b", f, bad, {coreClear, done, error});
      end
      checks++;
      if (exp_q.size() != 0) begin
        failures++;
        $display("FAIL random_writes frame=%0d missing=%0d required=0", f, exp_q.size());
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_known_frame();
    test_bad_chk();
    test_bad_len();
    test_reset_mid_frame();
    test_back_to_back();
    test_reload();
    test_random_frames();
    idle(4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
